// File: rtl/undolog_copy_engine.sv
// AXI4 burst copy master: reads NUM_BURSTS bursts from SRC_ADDR into a one-burst
// buffer and writes each back out to DST_ADDR, reporting TXN_DONE / sticky ERROR.
module undolog_copy_engine #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 8,
    parameter int NBURST_W  = 16
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                INIT_AXI_TXN,
    input  logic [ADDR_W-1:0]   SRC_ADDR,
    input  logic [ADDR_W-1:0]   DST_ADDR,
    input  logic [NBURST_W-1:0] NUM_BURSTS,
    output logic                TXN_DONE,
    output logic                ERROR,
    output logic                BUSY,
    // read address
    output logic [ADDR_W-1:0]   M_AXI_ARADDR,
    output logic [7:0]          M_AXI_ARLEN,
    output logic [2:0]          M_AXI_ARSIZE,
    output logic [1:0]          M_AXI_ARBURST,
    output logic [0:0]          M_AXI_ARID,
    output logic [3:0]          M_AXI_ARCACHE,
    output logic [2:0]          M_AXI_ARPROT,
    output logic                M_AXI_ARLOCK,
    output logic [3:0]          M_AXI_ARQOS,
    output logic                M_AXI_ARVALID,
    input  logic                M_AXI_ARREADY,
    // read data
    input  logic [DATA_W-1:0]   M_AXI_RDATA,
    input  logic [1:0]          M_AXI_RRESP,
    input  logic                M_AXI_RLAST,
    input  logic                M_AXI_RVALID,
    output logic                M_AXI_RREADY,
    // write address
    output logic [ADDR_W-1:0]   M_AXI_AWADDR,
    output logic [7:0]          M_AXI_AWLEN,
    output logic [2:0]          M_AXI_AWSIZE,
    output logic [1:0]          M_AXI_AWBURST,
    output logic [0:0]          M_AXI_AWID,
    output logic [3:0]          M_AXI_AWCACHE,
    output logic [2:0]          M_AXI_AWPROT,
    output logic                M_AXI_AWLOCK,
    output logic [3:0]          M_AXI_AWQOS,
    output logic                M_AXI_AWVALID,
    input  logic                M_AXI_AWREADY,
    // write data
    output logic [DATA_W-1:0]   M_AXI_WDATA,
    output logic [DATA_W/8-1:0] M_AXI_WSTRB,
    output logic                M_AXI_WLAST,
    output logic                M_AXI_WVALID,
    input  logic                M_AXI_WREADY,
    // write response
    input  logic [1:0]          M_AXI_BRESP,
    input  logic                M_AXI_BVALID,
    output logic                M_AXI_BREADY
);

    localparam int BYTES       = DATA_W / 8;
    localparam int BURST_BYTES = BURST_LEN * BYTES;
    localparam int ALIGN_W     = $clog2(BURST_BYTES);
    localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_DONE
    } state_e;

    state_e                state_q;
    logic                  init_q;
    logic [ADDR_W-1:0]     src_q, dst_q;
    logic [NBURST_W-1:0]   remain_q;
    logic [BEAT_W-1:0]     beat_q;
    logic                  arvalid_q, rready_q, awvalid_q, wvalid_q, wlast_q, bready_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  done_q, err_q, busy_q;
    logic [DATA_W-1:0]     mem_q [BURST_LEN];

    logic                  start, misaligned, rd_last, r_bad;
    logic [BEAT_W-1:0]     beat_nxt;

    assign start      = INIT_AXI_TXN & ~init_q;
    assign misaligned = (|SRC_ADDR[ALIGN_W-1:0]) | (|DST_ADDR[ALIGN_W-1:0]);
    assign rd_last    = (beat_q == LAST_BEAT);
    // The beat counter, not RLAST, ends the burst; a disagreeing RLAST is an error.
    assign r_bad      = (M_AXI_RRESP != 2'b00) | (M_AXI_RLAST != rd_last);
    assign beat_nxt   = beat_q + 1'b1;

    // Burst buffer has no reset: its contents are only read after being filled.
    always_ff @(posedge ACLK) begin
        if (state_q == S_RD_DATA && rready_q && M_AXI_RVALID)
            mem_q[beat_q] <= M_AXI_RDATA;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= S_IDLE;
            init_q    <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            remain_q  <= '0;
            beat_q    <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            init_q <= INIT_AXI_TXN;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        done_q   <= 1'b0;
                        err_q    <= 1'b0;
                        src_q    <= SRC_ADDR;
                        dst_q    <= DST_ADDR;
                        remain_q <= NUM_BURSTS;
                        beat_q   <= '0;
                        if (NUM_BURSTS == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (misaligned) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q   <= S_RD_ADDR;
                            arvalid_q <= 1'b1;
                            busy_q    <= 1'b1;
                        end
                    end
                end
                S_RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        if (r_bad)
                            err_q <= 1'b1;
                        if (rd_last) begin
                            beat_q   <= '0;
                            rready_q <= 1'b0;
                            // A bad read burst is drained fully but never written out.
                            if (err_q | r_bad) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q   <= S_WR_ADDR;
                                awvalid_q <= 1'b1;
                            end
                        end else begin
                            beat_q <= beat_nxt;
                        end
                    end
                end
                S_WR_ADDR: begin
                    if (M_AXI_AWREADY) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wdata_q   <= mem_q[0];
                        wlast_q   <= (BURST_LEN == 1);
                        beat_q    <= '0;
                        state_q   <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (M_AXI_WREADY) begin
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            beat_q   <= '0;
                            state_q  <= S_WR_RESP;
                        end else begin
                            beat_q  <= beat_nxt;
                            wdata_q <= mem_q[beat_nxt];
                            wlast_q <= (beat_nxt == LAST_BEAT);
                        end
                    end
                end
                S_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        bready_q <= 1'b0;
                        src_q    <= src_q + ADDR_STEP;
                        dst_q    <= dst_q + ADDR_STEP;
                        remain_q <= remain_q - 1'b1;
                        if (M_AXI_BRESP != 2'b00 || remain_q == NBURST_W'(1)) begin
                            if (M_AXI_BRESP != 2'b00)
                                err_q <= 1'b1;
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= S_RD_ADDR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign TXN_DONE      = done_q;
    assign ERROR         = err_q;
    assign BUSY          = busy_q;

    assign M_AXI_ARADDR  = src_q;
    assign M_AXI_ARLEN   = 8'(BURST_LEN - 1);
    assign M_AXI_ARSIZE  = 3'($clog2(BYTES));
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARCACHE = '0;
    assign M_AXI_ARPROT  = '0;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARQOS   = '0;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

    assign M_AXI_AWADDR  = dst_q;
    assign M_AXI_AWLEN   = 8'(BURST_LEN - 1);
    assign M_AXI_AWSIZE  = 3'($clog2(BYTES));
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWID    = '0;
    assign M_AXI_AWCACHE = '0;
    assign M_AXI_AWPROT  = '0;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWQOS   = '0;
    assign M_AXI_AWVALID = awvalid_q;

    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = wlast_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;

endmodule
